// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO stream reader: default widths and output buffer depth.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int BURST_LEN_DEF  = 4;
  localparam int BUF_DEPTH      = 3;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/stream_buf3.sv
// Three-entry ring buffer with push/pop/clear; head reads as zero when empty.
module stream_buf3
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_push  = i_push && ((r_count != 2'(BUF_DEPTH)) || w_pop);
  assign o_count = r_count;
  // Gating the head keeps the output quiet while empty and during reset.
  assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream with burst framing on m_last.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            level
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic       r_inflight;
  logic       r_run;
  logic [7:0] r_beat;
  logic [1:0] w_count;
  logic [2:0] w_committed;
  logic       w_hs;

  // Reads are only issued when a slot is guaranteed for the returning word.
  assign w_committed = {1'b0, w_count} + {2'b00, r_inflight};
  assign fifo_rd_en  = r_run && !fifo_empty && !flush && (w_committed < 3'(BUF_DEPTH));
  assign m_valid     = (w_count != 2'd0);
  assign w_hs        = m_valid && m_ready && !flush;
  assign m_last      = m_valid && (r_beat == LAST_BEAT);
  assign level       = w_count;

  stream_buf3 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight && !flush),
    .i_din   (fifo_dout),
    .i_pop   (w_hs),
    .i_clear (flush),
    .o_head  (m_data),
    .o_count (w_count)
  );

  // r_run holds off reads for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= 1'b0;
      r_run      <= 1'b0;
      r_beat     <= 8'd0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= fifo_rd_en;
      if (flush)     r_beat <= 8'd0;
      else if (w_hs) r_beat <= (r_beat == LAST_BEAT) ? 8'd0 : r_beat + 8'd1;
    end
  end

endmodule
